// File: rtl/if_id_pipe_buf_pkg.sv
// Shared pipeline-boundary definitions: NOP encoding, buffer states and occupancy width.
package if_id_pipe_buf_pkg;

    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0800;
    localparam int          PIPE_OCC_W        = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    function automatic logic [PIPE_OCC_W-1:0] occ_of_state(input buf_state_e st);
        logic [PIPE_OCC_W-1:0] occ;
        case (st)
            ST_ONE:  occ = 2'd1;
            ST_TWO:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/if_id_pipe_buf_entry.sv
// One buffer slot: a valid bit plus a data word that only changes on load.
module pipe_entry #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Clear only drops the valid bit; the stale data is masked by the consumer.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign q_valid = valid_q;
    assign q_data  = data_q;

endmodule

// File: rtl/if_id_pipe_buf.sv
// IF/ID boundary buffer with valid/ready handshake, flush-to-NOP and optional skid slot.
// Define IF_ID_SKID_EN for the two-entry build with a registered in_ready.
module if_id_pipe_buf
    import if_id_pipe_buf_pkg::*;
#(
    parameter int                 INSTR_W   = 16,
    parameter int                 PC_W      = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_W-1:0]    instruc_in,
    input  logic [PC_W-1:0]       seq_pc_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INSTR_W-1:0]    instruc_out,
    output logic [PC_W-1:0]       seq_pc_out,
    output logic [PIPE_OCC_W-1:0] occupancy
);

    localparam int DATA_W = INSTR_W + PC_W;

    // Handshake: a word moves on a side only in a cycle where both valid and ready are high.
    buf_state_e        state_q, state_d;
    logic              accept, consume;
    logic              main_valid, main_load, main_clear;
    logic [DATA_W-1:0] main_data, main_src;

`ifdef IF_ID_SKID_EN
    logic              in_ready_q, in_ready_d;
    logic              skid_valid, skid_load, skid_clear;
    logic [DATA_W-1:0] skid_data;
`endif

    assign accept  = in_valid & in_ready;
    assign consume = main_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_src   = {instruc_in, seq_pc_in};
`ifdef IF_ID_SKID_EN
        skid_load  = 1'b0;
        skid_clear = 1'b0;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    main_load = 1'b1;
`ifdef IF_ID_SKID_EN
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_d   = ST_TWO;
`endif
                end else if (consume) begin
                    main_clear = 1'b1;
                    state_d    = ST_EMPTY;
                end
            end
`ifdef IF_ID_SKID_EN
            ST_TWO: begin
                if (consume) begin
                    main_load  = 1'b1;
                    main_src   = skid_data;
                    skid_clear = 1'b1;
                    state_d    = ST_ONE;
                end
            end
`endif
            default: state_d = ST_EMPTY;
        endcase

        // A redirect squashes everything, including whatever fetch offers this cycle.
        if (flush) begin
            state_d    = ST_EMPTY;
            main_load  = 1'b0;
            main_clear = 1'b1;
`ifdef IF_ID_SKID_EN
            skid_load  = 1'b0;
            skid_clear = 1'b1;
`endif
        end
    end

`ifdef IF_ID_SKID_EN
    assign in_ready_d = (state_d != ST_TWO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;

    pipe_entry #(.DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_data  ({instruc_in, seq_pc_in}),
        .q_valid (skid_valid),
        .q_data  (skid_data)
    );
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_ready = ~main_valid | out_ready;
`endif

    pipe_entry #(.DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst_n   (rst),
        .load    (main_load),
        .clear   (main_clear),
        .d_data  (main_src),
        .q_valid (main_valid),
        .q_data  (main_data)
    );

    assign out_valid   = main_valid;
    assign instruc_out = main_valid ? main_data[DATA_W-1:PC_W] : NOP_INSTR;
    assign seq_pc_out  = main_valid ? main_data[PC_W-1:0] : '0;
    assign occupancy   = occ_of_state(state_q);

endmodule
